// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the imem address, queues {pc, inst}
// pairs in a DEPTH-entry FIFO and hands them to decode via valid/ready.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   o_addr_inst        word-aligned fetch address (the PC register)
//   i_inst             instruction returned combinationally for o_addr_inst
//   o_valid/o_pc/o_inst head of fetch queue (pc/inst forced to 0 when empty)
//   i_ready            decode accepts the head this cycle
//   i_redirect(_pc)    control-flow change: flush queue, refetch from target
//   o_stall_cnt        full-queue stall cycles
//
// Optional feature: define FETCH_STALL_CNT_EN to build the stall counter;
// otherwise o_stall_cnt is tied to zero.

module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_addr_inst,
    input  logic [31:0] i_inst,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] RST_PC = RESET_PC & 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    fq_entry_t         mem_q [DEPTH];
    fq_entry_t         mem_d [DEPTH];
    logic [31:0]       pc_q, pc_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic              pop;
    logic              push;
    fq_entry_t         head;

    // Low target bits are dropped: fetch is always word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    assign head        = mem_q[rd_q];
    assign o_valid     = (count_q != '0);
    assign o_pc        = o_valid ? head.pc : 32'h0;
    assign o_inst      = o_valid ? head.inst : 32'h0;
    assign o_addr_inst = pc_q;

    assign pop  = o_valid & i_ready;
    // A full queue can still accept a fetch when the head leaves this cycle.
    assign push = !i_redirect & ((count_q < FULL) | pop);

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mem_d   = mem_q;
        if (i_redirect) begin
            // Flush everything; the head seen this cycle is not consumed.
            pc_d    = {i_redirect_pc[31:2], 2'b00};
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = '{pc: pc_q, inst: i_inst};
                wr_d        = wr_q + AW'(1);
                pc_d        = pc_q + 32'd4;
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q    <= RST_PC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Payload storage needs no reset; count gates visibility.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!i_redirect && (count_q == FULL) && !pop) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected {pc, inst}
// pairs plus directed checks of reset, stall, redirect and wrap cases.

module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] hinst;
    logic        ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] stall;

    int n_chk;
    int n_bad;

    logic [63:0] sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_stall;

    fetch_unit #(
        .DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .o_addr_inst(addr),
        .i_inst(inst),
        .o_valid(valid),
        .o_pc(pc),
        .o_inst(hinst),
        .i_ready(ready),
        .i_redirect(redir),
        .i_redirect_pc(redir_pc),
        .o_stall_cnt(stall)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    assign inst = imem(addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are set by the caller; compare head, update model, clock once.
    task automatic tick();
        logic        m_valid;
        logic        m_pop;
        logic        m_full;
        logic [63:0] e;
        m_valid = (sb.size() != 0);
        m_full  = (sb.size() == DEPTH);
        chk("valid", {31'b0, valid}, {31'b0, m_valid});
        if (!m_valid) begin
            chk("pc_empty", pc, 32'h0);
            chk("inst_empty", hinst, 32'h0);
        end
        m_pop = m_valid && ready;
        if (rst) begin
            sb.delete();
            m_pc    = RPC;
            m_stall = 32'h0;
        end else if (redir) begin
            sb.delete();
            m_pc = {redir_pc[31:2], 2'b00};
        end else begin
            if (m_pop) begin
                e = sb.pop_front();
                chk("head_pc", pc, e[63:32]);
                chk("head_inst", hinst, e[31:0]);
            end
            if (m_full && !m_pop) begin
                m_stall = m_stall + 32'd1;
            end
            if (sb.size() < DEPTH) begin
                sb.push_back({m_pc, imem(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("addr", addr, m_pc);
`ifdef FETCH_STALL_CNT_EN
        chk("stall", stall, m_stall);
`else
        chk("stall", stall, 32'h0);
`endif
    endtask

    task automatic set_in(input logic r, input logic rd,
                          input logic rdir, input logic [31:0] t);
        rst      = r;
        ready    = rd;
        redir    = rdir;
        redir_pc = t;
    endtask

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        m_pc    = RPC;
        m_stall = 32'h0;
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", hinst, 32'h0);
        chk("rst_addr", addr, RPC);
        chk("rst_stall", stall, 32'h0);

        // streaming, one per cycle
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("s0_pc", pc, 32'h100);
        chk("s0_inst", hinst, 32'hA000_0040);
        tick();
        chk("s1_pc", pc, 32'h104);
        chk("s1_inst", hinst, 32'hA000_0041);
        tick();
        chk("s2_pc", pc, 32'h108);
        chk("s2_inst", hinst, 32'hA000_0042);
        repeat (3) tick();

        // fill with ready low
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (10) tick();
        chk("fill_addr", addr, 32'h110);
        chk("fill_pc", pc, 32'h100);
        chk("fill_inst", hinst, 32'hA000_0040);
`ifdef FETCH_STALL_CNT_EN
        chk("fill_stall", stall, 32'd6);
`endif

        // one pop while full
        ready = 1'b1;
        tick();
        chk("pp_pc", pc, 32'h104);
        chk("pp_addr", addr, 32'h114);
        chk("pp_valid", {31'b0, valid}, 32'h1);
        ready = 1'b0;
        repeat (2) tick();
        ready = 1'b1;
        repeat (6) tick();

        // redirect with three queued
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        set_in(1'b0, 1'b1, 1'b1, 32'h0000_0206);
        tick();
        chk("rd_valid", {31'b0, valid}, 32'h0);
        chk("rd_addr", addr, 32'h204);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("rd_pc", pc, 32'h204);
        repeat (5) tick();

        // redirect to top of address space
        set_in(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("wrap0", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap1", pc, 32'h0000_0000);
        tick();
        chk("wrap2", pc, 32'h0000_0004);

        // reset beats redirect
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (6) tick();
        set_in(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        tick();
        chk("rr_valid", {31'b0, valid}, 32'h0);
        chk("rr_addr", addr, RPC);
        chk("rr_stall", stall, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 99) == 0,
                   $urandom_range(0, 2) != 0,
                   $urandom_range(0, 19) == 0,
                   $urandom());
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
